// File: rtl/sobel_nms_pkg.sv
// sobel_pkg: shared constants, direction codes and FSM states for sobel_nms.
// No ports. Optional feature macro used by this slice: SOBEL_NMS_DIR_OUT_EN.
package sobel_pkg;

  localparam int AW = 20;
  localparam logic [AW-1:0] ANGLE_HALF_SECTOR = 20'h10000;
  localparam int RW = 12;

  typedef enum logic [1:0] {
    DIR_H    = 2'd0,
    DIR_D45  = 2'd1,
    DIR_V    = 2'd2,
    DIR_D135 = 2'd3
  } dir_e;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    ACTIVE     = 1'b1
  } state_e;

  // Rotate by half a sector so each 45 degree bin is centred on its
  // axis, then fold 180 degrees onto 0 by dropping the top bit.
  function automatic dir_e quant_dir(input logic [AW-1:0] angle);
    logic [AW-1:0] a;
    a = angle + ANGLE_HALF_SECTOR;
    return dir_e'(a[AW-2:AW-3]);
  endfunction

endpackage

// File: rtl/sobel_nms_if.sv
// sobel_nms_if: input gradient stream and output suppressed stream.
// master drives nms_din_*, slave drives nms_dout_* (+nms_dout_dir with SOBEL_NMS_DIR_OUT_EN).
interface sobel_nms_if #(
  parameter int DW = 8
);
  import sobel_pkg::*;

  logic          nms_din_vsync;
  logic          nms_din_hsync;
  logic [DW-1:0] nms_din_mag;
  logic [AW-1:0] nms_din_angle;
  logic          nms_dout_vsync;
  logic          nms_dout_hsync;
  logic [DW-1:0] nms_dout;

`ifdef SOBEL_NMS_DIR_OUT_EN
  logic [1:0]    nms_dout_dir;

  modport master (
    output nms_din_vsync, nms_din_hsync,
    output nms_din_mag, nms_din_angle,
    input  nms_dout_vsync, nms_dout_hsync,
    input  nms_dout, nms_dout_dir
  );

  modport slave (
    input  nms_din_vsync, nms_din_hsync,
    input  nms_din_mag, nms_din_angle,
    output nms_dout_vsync, nms_dout_hsync,
    output nms_dout, nms_dout_dir
  );
`else
  modport master (
    output nms_din_vsync, nms_din_hsync,
    output nms_din_mag, nms_din_angle,
    input  nms_dout_vsync, nms_dout_hsync,
    input  nms_dout
  );

  modport slave (
    input  nms_din_vsync, nms_din_hsync,
    input  nms_din_mag, nms_din_angle,
    output nms_dout_vsync, nms_dout_hsync,
    output nms_dout
  );
`endif

endinterface

// File: rtl/sobel_nms_line_buf.sv
// nms_line_buf: one-write/one-read register-array line buffer, async read.
// Ports: clk, we, waddr, wdata, raddr, rdata. Contents are never reset.
module nms_line_buf #(
  parameter int DEPTH = 640,
  parameter int AWID  = 10,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AWID-1:0]  waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AWID-1:0]  raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // A same-address read returns the old word, which is what lets the
  // two buffers be cascaded on a single column address.
  assign rdata = mem[raddr];

endmodule

// File: rtl/sobel_nms.sv
// sobel_nms: 3x3 non-maximum suppression on a magnitude/angle stream, 3 clk latency.
// Ports: clk, rst (sync, active high), nms (sobel_nms_if.slave). Macro: SOBEL_NMS_DIR_OUT_EN.
module sobel_nms
  import sobel_pkg::*;
#(
  parameter int DW    = 8,
  parameter int IW    = 640,
  parameter int IW_DW = 10
) (
  input  logic       clk,
  input  logic       rst,
  sobel_nms_if.slave nms
);

  localparam int LBA = (IW > 1) ? $clog2(IW) : 1;
  localparam int LW  = DW + 2;
  localparam logic [IW_DW-1:0] COL_MAX = IW_DW'(IW - 1);
  localparam logic [RW-1:0]    ROW_MAX = '1;

  state_e state;
  state_e state_nxt;

  logic             vs_d;
  logic             hs_d;
  logic             vs_rise;
  logic             vs_fall;
  logic             hs_fall;
  logic             pass;
  logic [IW_DW-1:0] col;
  logic [RW-1:0]    row;
  logic             ovf;
  logic             pix_ok;
  logic [1:0]       din_dir;
  logic [LW-1:0]    lb1_wd;
  logic [LW-1:0]    lb1_rd;
  logic [DW-1:0]    lb2_rd;

  assign vs_rise = nms.nms_din_vsync & ~vs_d;
  assign vs_fall = ~nms.nms_din_vsync & vs_d;
  assign hs_fall = ~nms.nms_din_hsync & hs_d;
  assign pix_ok  = nms.nms_din_hsync & ~ovf;
  assign din_dir = quant_dir(nms.nms_din_angle);
  assign lb1_wd  = {din_dir, nms.nms_din_mag};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_FRAME;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      WAIT_FRAME: if (vs_rise) state_nxt = ACTIVE;
      ACTIVE:     if (vs_fall) state_nxt = WAIT_FRAME;
    endcase
  end

  // Gate on the next state so the first pixel of a frame already passes.
  assign pass = (state_nxt == ACTIVE);

  // vs_d resets high: a frame already running when reset drops
  // must not look like a fresh vsync rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d <= 1'b1;
      hs_d <= 1'b0;
      col  <= '0;
      row  <= '0;
      ovf  <= 1'b0;
    end else begin
      vs_d <= nms.nms_din_vsync;
      hs_d <= nms.nms_din_hsync;
      if (hs_fall) begin
        col <= '0;
        ovf <= 1'b0;
        if (row != ROW_MAX) row <= row + 1'b1;
      end else if (pix_ok) begin
        if (col == COL_MAX) ovf <= 1'b1;
        else col <= col + 1'b1;
      end
      if (vs_rise) row <= '0;
    end
  end

  // lb1 holds line r-1 (mag + dir); lb2 holds line r-2, magnitude
  // only, since direction is needed just for the centre row.
  nms_line_buf #(
    .DEPTH (IW),
    .AWID  (LBA),
    .WIDTH (LW)
  ) u_lb1 (
    .clk   (clk),
    .we    (pix_ok),
    .waddr (col[LBA-1:0]),
    .wdata (lb1_wd),
    .raddr (col[LBA-1:0]),
    .rdata (lb1_rd)
  );

  nms_line_buf #(
    .DEPTH (IW),
    .AWID  (LBA),
    .WIDTH (DW)
  ) u_lb2 (
    .clk   (clk),
    .we    (pix_ok),
    .waddr (col[LBA-1:0]),
    .wdata (lb1_rd[DW-1:0]),
    .raddr (col[LBA-1:0]),
    .rdata (lb2_rd)
  );

  // Window: index 0 = newest column c, 1 = centre c-1, 2 = c-2.
  // t = line r-2 (north), m = line r-1 (centre), b = line r (south).
  logic [DW-1:0] win_t [3];
  logic [DW-1:0] win_m [3];
  logic [DW-1:0] win_b [3];
  logic [1:0]    dir_m0;
  logic [1:0]    dir_m1;
  logic          s1_ok;
  logic          s1_vs;
  logic          s1_hs;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        win_t[i] <= '0;
        win_m[i] <= '0;
        win_b[i] <= '0;
      end
      dir_m0 <= '0;
      dir_m1 <= '0;
      s1_ok  <= 1'b0;
      s1_vs  <= 1'b0;
      s1_hs  <= 1'b0;
    end else begin
      s1_vs <= nms.nms_din_vsync & pass;
      s1_hs <= nms.nms_din_hsync & pass;
      s1_ok <= pix_ok & pass
             & (row >= RW'(2))
             & (col >= IW_DW'(2));
      if (pix_ok) begin
        win_t[0] <= lb2_rd;
        win_t[1] <= win_t[0];
        win_t[2] <= win_t[1];
        win_m[0] <= lb1_rd[DW-1:0];
        win_m[1] <= win_m[0];
        win_m[2] <= win_m[1];
        win_b[0] <= nms.nms_din_mag;
        win_b[1] <= win_b[0];
        win_b[2] <= win_b[1];
        dir_m0   <= lb1_rd[LW-1:DW];
        dir_m1   <= dir_m0;
      end
    end
  end

  dir_e          c_dir;
  logic [DW-1:0] c_mag;
  logic [DW-1:0] n1;
  logic [DW-1:0] n2;
  logic          keep;

  // n1 gets >=, n2 gets >: on a flat plateau only the last pixel
  // along the scan direction survives.
  always_comb begin
    c_dir = dir_e'(dir_m1);
    c_mag = win_m[1];
    n1    = win_m[2];
    n2    = win_m[0];
    unique case (1'b1)
      (c_dir == DIR_H): begin
        n1 = win_m[2];
        n2 = win_m[0];
      end
      (c_dir == DIR_D45): begin
        n1 = win_t[0];
        n2 = win_b[2];
      end
      (c_dir == DIR_V): begin
        n1 = win_t[1];
        n2 = win_b[1];
      end
      (c_dir == DIR_D135): begin
        n1 = win_t[2];
        n2 = win_b[0];
      end
    endcase
    keep = s1_ok & (c_mag >= n1) & (c_mag > n2);
  end

  logic          s2_vs;
  logic          s2_hs;
  logic [DW-1:0] s2_mag;
`ifdef SOBEL_NMS_DIR_OUT_EN
  logic [1:0]    s2_dir;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vs  <= 1'b0;
      s2_hs  <= 1'b0;
      s2_mag <= '0;
`ifdef SOBEL_NMS_DIR_OUT_EN
      s2_dir <= '0;
`endif
    end else begin
      s2_vs  <= s1_vs;
      s2_hs  <= s1_hs;
      s2_mag <= keep ? c_mag : '0;
`ifdef SOBEL_NMS_DIR_OUT_EN
      s2_dir <= (keep && c_mag != '0) ? c_dir : DIR_H;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nms.nms_dout_vsync <= 1'b0;
      nms.nms_dout_hsync <= 1'b0;
      nms.nms_dout       <= '0;
`ifdef SOBEL_NMS_DIR_OUT_EN
      nms.nms_dout_dir   <= '0;
`endif
    end else begin
      nms.nms_dout_vsync <= s2_vs;
      nms.nms_dout_hsync <= s2_hs;
      nms.nms_dout       <= s2_mag;
`ifdef SOBEL_NMS_DIR_OUT_EN
      nms.nms_dout_dir   <= s2_dir;
`endif
    end
  end

endmodule

// File: tb/tb_sobel_nms.sv
// tb_sobel_nms: randomized + directed frames checked against a behavioural NMS model.
// DUT: sobel_nms with IW=8, 6 lines per frame.
module tb_sobel_nms;

  localparam int IW = 8;
  localparam int NR = 6;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sobel_nms_if #(.DW(DW)) nif ();

  sobel_nms #(
    .DW    (DW),
    .IW    (IW),
    .IW_DW (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .nms (nif)
  );

  typedef struct packed {
    logic       vs;
    logic       hs;
    logic [7:0] d;
    logic [1:0] dir;
  } exp_t;

  logic [7:0]  img_mag [NR][IW];
  logic [19:0] img_ang [NR][IW];
  exp_t        q [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          discard = 1'b0;
  string       cur     = "none";

  function automatic int qdir(input logic [19:0] a);
    return ((int'(a) + 65536) % 1048576) / 131072 % 4;
  endfunction

  // Centre (r-1,c-1) vs its two neighbours along the gradient;
  // the second neighbour is the point mirrored through the centre.
  function automatic exp_t ref_out(input bit vs, input bit hs,
                                   input int r, input int c);
    exp_t e;
    int cr, cc, d, dr, dc;
    logic [7:0] cm, n1, n2;
    e = '0;
    if (discard) return e;
    e.vs = vs;
    e.hs = hs;
    if (hs && r >= 2 && c >= 2 && c < IW) begin
      cr = r - 1;
      cc = c - 1;
      d  = qdir(img_ang[cr][cc]);
      case (d)
        0:       begin dr = 0;  dc = -1; end
        1:       begin dr = -1; dc = 1;  end
        2:       begin dr = -1; dc = 0;  end
        default: begin dr = -1; dc = -1; end
      endcase
      cm = img_mag[cr][cc];
      n1 = img_mag[cr+dr][cc+dc];
      n2 = img_mag[cr-dr][cc-dc];
      if (cm >= n1 && cm > n2) begin
        e.d = cm;
        if (cm != 0) e.dir = 2'(d);
      end
    end
    return e;
  endfunction

  task automatic step(input bit vs, input bit hs, input logic [7:0] m,
                      input logic [19:0] a, input int r, input int c,
                      input bit rs);
    exp_t e;
    @(negedge clk);
    if (q.size() >= 3) begin
      e = q.pop_front();
      n_tests++;
      if ({nif.nms_dout_vsync, nif.nms_dout_hsync, nif.nms_dout}
          !== {e.vs, e.hs, e.d}) begin
        n_fail++;
        $display("FAIL %s t=%0t: got vs=%0b hs=%0b d=%0d, want vs=%0b hs=%0b d=%0d",
                 cur, $time, nif.nms_dout_vsync, nif.nms_dout_hsync,
                 nif.nms_dout, e.vs, e.hs, e.d);
      end
`ifdef SOBEL_NMS_DIR_OUT_EN
      n_tests++;
      if (nif.nms_dout_dir !== e.dir) begin
        n_fail++;
        $display("FAIL %s_dir t=%0t: got %0d want %0d",
                 cur, $time, nif.nms_dout_dir, e.dir);
      end
`endif
    end
    rst               = rs;
    nif.nms_din_vsync = vs;
    nif.nms_din_hsync = hs;
    nif.nms_din_mag   = m;
    nif.nms_din_angle = a;
    q.push_back(ref_out(vs, hs, r, c));
  endtask

  task automatic idle(input bit vs, input int n);
    for (int i = 0; i < n; i++) step(vs, 1'b0, 8'd0, 20'd0, 0, 0, 1'b0);
  endtask

  task automatic run_frame(input int hlen, input int gap, input int tail);
    logic [7:0]  m;
    logic [19:0] a;
    idle(1'b1, 2);
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < hlen; c++) begin
        m = 8'($urandom);
        a = 20'($urandom);
        if (c < IW) begin
          m = img_mag[r][c];
          a = img_ang[r][c];
        end
        step(1'b1, 1'b1, m, a, r, c, 1'b0);
      end
      idle(1'b1, gap);
    end
    idle(1'b0, tail);
  endtask

  task automatic fill_random(input int maxv);
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < IW; c++) begin
        img_mag[r][c] = 8'($urandom_range(0, maxv));
        img_ang[r][c] = 20'($urandom);
      end
  endtask

  task automatic fill_ridge(input logic [19:0] a0, input logic [19:0] a1);
    logic [7:0] prof [IW];
    prof = '{8'd10, 8'd20, 8'd40, 8'd20, 8'd10, 8'd0, 8'd0, 8'd0};
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < IW; c++) begin
        img_mag[r][c] = prof[c];
        img_ang[r][c] = ((r + c) % 2 == 0) ? a0 : a1;
      end
  endtask

  task automatic test_reset();
    cur = "reset";
    rst = 1'b1;
    nif.nms_din_vsync = 1'b0;
    nif.nms_din_hsync = 1'b0;
    nif.nms_din_mag   = '0;
    nif.nms_din_angle = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({nif.nms_dout_vsync, nif.nms_dout_hsync, nif.nms_dout} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_state: got vs=%0b hs=%0b d=%0d, want 0 0 0",
               nif.nms_dout_vsync, nif.nms_dout_hsync, nif.nms_dout);
    end
    q.delete();
    repeat (3) q.push_back('0);
    idle(1'b0, 3);
  endtask

  task automatic test_ridge_h();
    cur = "ridge_h";
    fill_ridge(20'd0, 20'd0);
    run_frame(IW, 4, 3);
  endtask

  task automatic test_ridge_v();
    cur = "ridge_v";
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < IW; c++) begin
        img_mag[r][c] = (r == 3) ? 8'd90 : 8'd30;
        img_ang[r][c] = 20'd262144;
      end
    run_frame(IW, 4, 3);
  endtask

  task automatic test_plateau();
    cur = "plateau";
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < IW; c++) begin
        img_mag[r][c] = 8'd0;
        img_ang[r][c] = 20'd0;
      end
    img_mag[2][1] = 8'd10;
    img_mag[2][2] = 8'd50;
    img_mag[2][3] = 8'd50;
    img_mag[2][4] = 8'd10;
    run_frame(IW, 4, 3);
  endtask

  task automatic test_angle_wrap();
    cur = "angle_wrap";
    fill_ridge(20'hFFFFF, 20'h7FFFF);
    run_frame(IW, 4, 3);
  endtask

  task automatic test_diag();
    cur = "diag";
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < IW; c++) begin
        img_mag[r][c] = (r == c) ? 8'd60 : 8'd15;
        img_ang[r][c] = 20'd131072;
      end
    run_frame(IW, 4, 3);
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      cur = (k < 2) ? "random_wide" : "random_ties";
      fill_random((k < 2) ? 255 : 3);
      run_frame(IW, 4, 3);
    end
  endtask

  task automatic test_long_line();
    cur = "long_line";
    fill_random(255);
    run_frame(IW + 3, 4, 3);
  endtask

  task automatic test_back_to_back();
    cur = "back_to_back";
    for (int k = 0; k < 2; k++) begin
      fill_random(15);
      run_frame(IW, 1, 1);
    end
    idle(1'b0, 3);
  endtask

  task automatic test_reset_mid_frame();
    int rc;
    cur = "reset_mid";
    fill_random(255);
    rc = 0;
    idle(1'b1, 2);
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < IW; c++) begin
        if (r == 3 && c == 3) begin
          step(1'b1, 1'b1, img_mag[r][c], img_ang[r][c], r, c, 1'b1);
          q.delete();
          repeat (3) q.push_back('0);
          discard = 1'b1;
        end else if (discard && rc < 2) begin
          step(1'b1, 1'b1, img_mag[r][c], img_ang[r][c], r, c, 1'b1);
          rc++;
        end else begin
          step(1'b1, 1'b1, img_mag[r][c], img_ang[r][c], r, c, 1'b0);
        end
      end
      idle(1'b1, 4);
    end
    idle(1'b0, 3);
    discard = 1'b0;
    cur = "after_reset";
    fill_ridge(20'd0, 20'd0);
    run_frame(IW, 4, 3);
  endtask

  initial begin
    test_reset();
    test_ridge_h();
    test_ridge_v();
    test_plateau();
    test_angle_wrap();
    test_diag();
    test_random();
    test_long_line();
    test_back_to_back();
    test_reset_mid_frame();
    idle(1'b0, 4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
